axisarbiter: RTL and testbench
==============================

# axisarbiter

Packet-level round-robin arbiter that shares one downstream AXI-Stream channel between NIN upstream AXI-Stream sources. A grant is held from the first beat through the TLAST beat of a packet, so packets are never interleaved. The output is fully registered and tags each beat with the index of its source. The block sits in front of any single-consumer stream stage, such as a registered stream buffer, that several producers must share.

## Interface

Parameters:
- NIN, 4: number of upstream sources; 2 to 16.
- DW, 16: data width in bits.
- LGNIN, $clog2(NIN): width of the source index; derived, not overridden.

Ports:
- S_AXI_ACLK, input, 1: the single clock; all state changes on its rising edge.
- S_AXI_ARESETN, input, 1: reset is asynchronous and active-low.
- S_AXIS_TVALID, input, NIN: per-source valid; bit i belongs to source i.
- S_AXIS_TREADY, output, NIN: per-source ready; combinational from registered state.
- S_AXIS_TDATA, input, NIN*DW: source i occupies bits [i*DW +: DW].
- S_AXIS_TLAST, input, NIN: per-source end-of-packet.
- M_AXIS_TVALID, output, 1: registered output valid.
- M_AXIS_TREADY, input, 1: downstream ready.
- M_AXIS_TDATA, output, DW: registered output data.
- M_AXIS_TLAST, output, 1: registered end-of-packet.
- M_AXIS_TID, output, LGNIN: registered index of the source that produced the current beat.

## Operation

- The state machine has two states, IDLE and GRANTED.
- Internal registers: grant index `grant` [LGNIN], and round-robin pointer `last` [LGNIN] holding the most recently granted source.
- Asynchronous reset drives the following. State goes to IDLE, `grant` to 0, and `last` to NIN-1, so source 0 has first priority. M_AXIS_TVALID, M_AXIS_TLAST and M_AXIS_TID go to 0. M_AXIS_TDATA goes to 0. S_AXIS_TREADY is all zero in IDLE.
- IDLE, no TVALID set: stay in IDLE.
- IDLE, any TVALID set: choose the first i with TVALID[i]=1, searching last+1, last+2, … with wrap modulo NIN. Set grant=i and last=i, then go to GRANTED.
- Source indices at or above NIN do not exist. The search wraps at NIN, not at 2^LGNIN.
- GRANTED, ready rule: S_AXIS_TREADY[grant] = !M_AXIS_TVALID || M_AXIS_TREADY. All other ready bits are 0.
- GRANTED, beat transfer: a beat transfers when TVALID[grant] and TREADY[grant] are both 1. On that edge the output registers load. M_AXIS_TVALID becomes 1. M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TID load the granted source's data, last bit and index.
- GRANTED, no transfer: if M_AXIS_TREADY=1 and no beat transfers, M_AXIS_TVALID goes to 0.
- GRANTED, packet end: a transferring beat with TLAST=1 returns the state to IDLE on the same edge.
- The grant never changes mid-packet. If the granted source deasserts TVALID, the block waits and the other sources stay stalled.
- Output registers in IDLE: M_AXIS_TVALID clears when M_AXIS_TREADY=1 and holds otherwise. The data, last and TID registers hold.
- Output stability: while M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TID stay stable.

## Timing

- Arbitration latency: a request seen in IDLE in cycle 0 gives TREADY in cycle 1. The first beat is accepted at the end of cycle 1 and appears on M_AXIS in cycle 2.
- Throughput: one beat per cycle within a packet while downstream is ready.
- There is exactly one idle arbitration cycle between consecutive packets, including back-to-back packets from the same source.
- Single-beat packets (TLAST on the first beat) are legal. They cost two cycles each.
- Simultaneous TLAST transfer and new requests: the state goes to IDLE and the new grant is decided in the following cycle from the updated `last`.
- Downstream stall: TREADY[grant] drops in the same cycle as M_AXIS_TVALID && !M_AXIS_TREADY. No beat is lost or duplicated.
- Upstream contract: once a source raises TVALID, it keeps TVALID, TDATA and TLAST stable until accepted.
- Reset mid-packet: everything clears immediately, regardless of clock. The partial packet is abandoned, and the first post-reset grant goes to the lowest-index requester.
- Formal properties the block must satisfy:
  - At most one TREADY bit is set.
  - TREADY[i] implies state GRANTED and grant==i.
  - M_AXIS is stable while stalled.
  - M_AXIS_TVALID is 0 in the first cycle after reset release.

## Test plan

- Single source: source 2 sends a 3-beat packet with data 0xA1, 0xA2, 0xA3 and TLAST on 0xA3, M_AXIS_TREADY=1. Expect M_AXIS to show 0xA1 to 0xA3 in cycles 2 to 4 with TID=2, and TLAST only on 0xA3.
- Round robin, all four sources each holding a 1-beat packet continuously from reset. Expect TID to follow 0,1,2,3,0,… with one bubble cycle between grants.
- No interleave: source 0 sends a 4-beat packet and idles TVALID for 2 cycles after beat 2, while source 1 requests throughout. Expect all 4 source-0 beats before any TID=1 beat, and TREADY[1]=0 during the gap.
- Backpressure: M_AXIS_TREADY toggles 1,0,0,1 during a 5-beat packet 0x10 to 0x14. Expect output stable while stalled, all beats delivered once and in order, and TREADY low exactly when output is full and stalled.
- Wrap and skip: last=3 and only sources 1 and 3 requesting. Expect the grant to go to 1, then 3, then 1.
- Reset mid-packet: assert S_AXI_ARESETN low between clock edges after beat 2 of 4. Expect M_AXIS_TVALID=0 and all TREADY=0 immediately, and the next grant to go to the lowest-index requester.

Source files
------------

// File: rtl/axisarbiter_if.sv
// Stream bundle for axisarbiter: NIN upstream AXI-Stream sources and one tagged downstream channel.
interface axisarbiter_if #(
  parameter int unsigned NIN   = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned LGNIN = $clog2(NIN)
);
  logic [NIN-1:0]    S_AXIS_TVALID;
  logic [NIN-1:0]    S_AXIS_TREADY;
  logic [NIN*DW-1:0] S_AXIS_TDATA;
  logic [NIN-1:0]    S_AXIS_TLAST;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TREADY;
  logic [DW-1:0]     M_AXIS_TDATA;
  logic              M_AXIS_TLAST;
  logic [LGNIN-1:0]  M_AXIS_TID;

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TID
  );

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TID
  );
endinterface

// File: rtl/axisarbiter.sv
// Packet-level round-robin arbiter: NIN AXI-Stream sources share one registered output,
// each beat tagged with its source index; a grant is held from first beat to TLAST.
module axisarbiter #(
  parameter int unsigned NIN   = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned LGNIN = $clog2(NIN)
) (
  input logic          S_AXI_ACLK,
  input logic          S_AXI_ARESETN,
  axisarbiter_if.slave axis
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [LGNIN-1:0] grant_q, grant_d;
  logic [LGNIN-1:0] last_q, last_d;
  logic             mvalid_q, mvalid_d;
  logic [DW-1:0]    mdata_q, mdata_d;
  logic             mlast_q, mlast_d;
  logic [LGNIN-1:0] mtid_q, mtid_d;
  logic [NIN-1:0]   sready;
  logic             can_take;
  logic             beat;
  logic [LGNIN-1:0] pick;

  // Search starts one past the last grant and wraps at NIN, not at 2^LGNIN.
  function automatic logic [LGNIN-1:0] rr_pick(input logic [LGNIN-1:0] last,
                                               input logic [NIN-1:0]   req);
    logic [LGNIN-1:0] r;
    logic [LGNIN-1:0] ix;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NIN; k++) begin
      ix = LGNIN'((32'(last) + k) % NIN);
      if (!found && req[ix]) begin
        r     = ix;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign pick = rr_pick(last_q, axis.S_AXIS_TVALID);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    mtid_d   = mtid_q;
    sready   = '0;
    can_take = 1'b0;
    beat     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (axis.M_AXIS_TREADY) mvalid_d = 1'b0;
        if (|axis.S_AXIS_TVALID) begin
          grant_d = pick;
          last_d  = pick;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        can_take        = !mvalid_q || axis.M_AXIS_TREADY;
        sready[grant_q] = can_take;
        beat            = axis.S_AXIS_TVALID[grant_q] && can_take;
        if (beat) begin
          mvalid_d = 1'b1;
          mdata_d  = axis.S_AXIS_TDATA[32'(grant_q)*DW +: DW];
          mlast_d  = axis.S_AXIS_TLAST[grant_q];
          mtid_d   = grant_q;
          if (axis.S_AXIS_TLAST[grant_q]) state_d = IDLE;
        end else if (axis.M_AXIS_TREADY) begin
          mvalid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= LGNIN'(NIN - 1);
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mlast_q  <= 1'b0;
      mtid_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
      mtid_q   <= mtid_d;
    end
  end

  assign axis.S_AXIS_TREADY = sready;
  assign axis.M_AXIS_TVALID = mvalid_q;
  assign axis.M_AXIS_TDATA  = mdata_q;
  assign axis.M_AXIS_TLAST  = mlast_q;
  assign axis.M_AXIS_TID    = mtid_q;

endmodule

// File: tb/tb_axisarbiter.sv
// Scoreboard bench for axisarbiter: per-source beat queues feed the DUT, expected output
// beats are queued at stimulus time and popped by an independent monitor.
module tb_axisarbiter;

  localparam int unsigned NIN = 4;
  localparam int unsigned DW  = 16;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int unsigned pre;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic [1:0]  tid;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;
  int   stall_seen;

  beat_t srcq[4][$];
  exp_t  expq[$];
  int    beat_cyc[$];

  axisarbiter_if #(.NIN(NIN), .DW(DW)) axis ();

  axisarbiter #(.NIN(NIN), .DW(DW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .axis          (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic put_beat(input int s, input logic [15:0] d, input logic l, input int unsigned pre);
    beat_t b;
    b.d = d; b.l = l; b.pre = pre;
    srcq[s].push_back(b);
  endtask

  task automatic put_exp(input logic [15:0] d, input logic l, input logic [1:0] tid);
    exp_t e;
    e.d = d; e.l = l; e.tid = tid;
    expq.push_back(e);
  endtask

  // Source model: presents queue heads at negedge, samples handshakes just before posedge.
  initial begin
    logic [3:0]  acc;
    logic [3:0]  tv;
    logic [3:0]  tl;
    logic [63:0] tdat;
    beat_t       h;
    acc  = '0;
    tl   = '0;
    tdat = '0;
    axis.S_AXIS_TVALID = '0;
    axis.S_AXIS_TLAST  = '0;
    axis.S_AXIS_TDATA  = '0;
    forever begin
      @(negedge clk);
      tv = '0;
      for (int s = 0; s < 4; s++) begin
        if (acc[s] && srcq[s].size() > 0) h = srcq[s].pop_front();
        if (srcq[s].size() > 0) begin
          h = srcq[s][0];
          if (h.pre > 0) begin
            h.pre--;
            srcq[s][0] = h;
          end else begin
            tv[s]            = 1'b1;
            tl[s]            = h.l;
            tdat[s*16 +: 16] = h.d;
          end
        end
      end
      axis.S_AXIS_TVALID = tv;
      axis.S_AXIS_TLAST  = tl;
      axis.S_AXIS_TDATA  = tdat;
      #4;
      acc = rst_n ? (axis.S_AXIS_TVALID & axis.S_AXIS_TREADY) : 4'b0;
    end
  end

  // Monitor: scoreboard pop on each output handshake, plus stall stability and ready rules.
  initial begin
    logic        prev_stall;
    logic [15:0] pd;
    logic        pl;
    logic [1:0]  pt;
    exp_t        e;
    prev_stall = 1'b0;
    pd = '0; pl = 1'b0; pt = '0;
    stall_seen = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold",
                {12'h0, axis.M_AXIS_TVALID, axis.M_AXIS_TLAST, axis.M_AXIS_TID, axis.M_AXIS_TDATA},
                {12'h0, 1'b1, pl, pt, pd});
        if (axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY) begin
          stall_seen++;
          check("stall_tready", 32'(axis.S_AXIS_TREADY), 32'h0);
        end
        if (axis.S_AXIS_TREADY != 4'b0)
          check("tready_onehot", 32'($countones(axis.S_AXIS_TREADY)), 32'd1);
        if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
          beat_cyc.push_back(cyc);
          if (expq.size() == 0) begin
            check("unexpected_beat",
                  {13'h0, axis.M_AXIS_TLAST, axis.M_AXIS_TID, axis.M_AXIS_TDATA}, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            check("beat",
                  {13'h0, axis.M_AXIS_TLAST, axis.M_AXIS_TID, axis.M_AXIS_TDATA},
                  {13'h0, e.l, e.tid, e.d});
          end
        end
        prev_stall = axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY;
        pd = axis.M_AXIS_TDATA;
        pl = axis.M_AXIS_TLAST;
        pt = axis.M_AXIS_TID;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    axis.M_AXIS_TREADY = 1'b1;
    for (int s = 0; s < 4; s++) srcq[s].delete();
    expq.delete();
    beat_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_drain"}, 32'(expq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    int         n;
    logic [3:0] pat;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    axis.M_AXIS_TREADY = 1'b1;
    #3;
    check("rst_outputs",
          {12'h0, axis.M_AXIS_TVALID, axis.M_AXIS_TLAST, axis.M_AXIS_TID, axis.M_AXIS_TDATA}, 32'h0);
    check("rst_tready", 32'(axis.S_AXIS_TREADY), 32'h0);
    put_beat(3, 16'h00EE, 1'b1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(axis.M_AXIS_TVALID), 32'h0);

    // Single source, 3 beats, first beat two cycles after request.
    do_reset();
    c = cyc;
    put_beat(2, 16'h00A1, 1'b0, 0);
    put_beat(2, 16'h00A2, 1'b0, 0);
    put_beat(2, 16'h00A3, 1'b1, 0);
    put_exp(16'h00A1, 1'b0, 2'd2);
    put_exp(16'h00A2, 1'b0, 2'd2);
    put_exp(16'h00A3, 1'b1, 2'd2);
    wait_drain(30, "single");
    check("single_count", 32'(beat_cyc.size()), 32'd3);
    if (beat_cyc.size() >= 3)
      for (int i = 0; i < 3; i++) check("single_cycle", 32'(beat_cyc[i] - c), 32'(2 + i));

    // Round robin: every source holds two 1-beat packets.
    do_reset();
    c = cyc;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 4; s++) begin
        put_beat(s, 16'(16'h0030 + 16*k + s), 1'b1, 0);
        put_exp(16'(16'h0030 + 16*k + s), 1'b1, 2'(s));
      end
    wait_drain(60, "rr");
    check("rr_count", 32'(beat_cyc.size()), 32'd8);
    if (beat_cyc.size() >= 8)
      for (int i = 0; i < 8; i++) check("rr_cycle", 32'(beat_cyc[i] - c), 32'(2 + 2*i));

    // No interleave: source 0 pauses 2 cycles mid-packet while source 1 waits.
    do_reset();
    put_beat(0, 16'h0020, 1'b0, 0);
    put_beat(0, 16'h0021, 1'b0, 0);
    put_beat(0, 16'h0022, 1'b0, 2);
    put_beat(0, 16'h0023, 1'b1, 0);
    put_beat(1, 16'h002F, 1'b1, 0);
    put_exp(16'h0020, 1'b0, 2'd0);
    put_exp(16'h0021, 1'b0, 2'd0);
    put_exp(16'h0022, 1'b0, 2'd0);
    put_exp(16'h0023, 1'b1, 2'd0);
    put_exp(16'h002F, 1'b1, 2'd1);
    n = 0;
    while (beat_cyc.size() < 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    #3;
    check("gap_tready", 32'(axis.S_AXIS_TREADY), 32'h1);
    check("gap_src1_valid", 32'(axis.S_AXIS_TVALID[1]), 32'h1);
    wait_drain(40, "interleave");

    // Backpressure: downstream ready follows 1,0,0,1 repeatedly through a 5-beat packet.
    do_reset();
    stall_seen = 0;
    for (int i = 0; i < 5; i++) begin
      put_beat(1, 16'(16'h0010 + i), 1'(i == 4), 0);
      put_exp(16'(16'h0010 + i), 1'(i == 4), 2'd1);
    end
    pat = 4'b1001;
    n = 0;
    while (expq.size() != 0 && n < 60) begin
      @(negedge clk);
      axis.M_AXIS_TREADY = pat[n % 4];
      n++;
    end
    @(negedge clk);
    axis.M_AXIS_TREADY = 1'b1;
    wait_drain(20, "bp");
    check("bp_stalled", 32'(stall_seen > 0), 32'd1);

    // Wrap and skip: after reset last=3, sources 1 and 3 requesting.
    do_reset();
    put_beat(1, 16'h0071, 1'b1, 0);
    put_beat(1, 16'h0072, 1'b1, 0);
    put_beat(3, 16'h0073, 1'b1, 0);
    put_exp(16'h0071, 1'b1, 2'd1);
    put_exp(16'h0073, 1'b1, 2'd3);
    put_exp(16'h0072, 1'b1, 2'd1);
    wait_drain(30, "wrap");

    // Reset between edges after beat 2 of a 4-beat packet; partial packet is abandoned.
    do_reset();
    for (int i = 0; i < 4; i++) put_beat(0, 16'(16'h0050 + i), 1'(i == 3), 0);
    put_beat(1, 16'h0061, 1'b1, 0);
    put_beat(3, 16'h0063, 1'b1, 0);
    put_exp(16'h0050, 1'b0, 2'd0);
    put_exp(16'h0051, 1'b0, 2'd0);
    put_exp(16'h0061, 1'b1, 2'd1);
    put_exp(16'h0063, 1'b1, 2'd3);
    n = 0;
    while (beat_cyc.size() < 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    rst_n = 1'b0;
    srcq[0].delete();
    #1;
    check("midrst_valid", 32'(axis.M_AXIS_TVALID), 32'h0);
    check("midrst_tready", 32'(axis.S_AXIS_TREADY), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_first_valid", 32'(axis.M_AXIS_TVALID), 32'h0);
    wait_drain(30, "midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
